// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU request/response and RAM strobe bundle for mem_ctrl.
interface mem_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_dout,
        output cpu_ack, cpu_err, cpu_rdata, ram_read, ram_write, ram_addr, ram_din
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_dout,
        input  cpu_ack, cpu_err, cpu_rdata, ram_read, ram_write, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: range-checked single-outstanding load/store sequencer for a negedge RAM.
// All outputs are flops; ram_addr/ram_din double as the latched request.
module mem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        clr,
    mem_ctrl_if.slave   bus,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ACK    = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ram_read_q, ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              oor;

    assign oor = |bus.cpu_addr[31:ADDR_W];

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        wait_d      = wait_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rdata_d     = rdata_q;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        if (state_q == IDLE && bus.cpu_req) begin
            we_d        = bus.cpu_we;
            ram_addr_d  = bus.cpu_addr[ADDR_W-1:0];
            ram_din_d   = bus.cpu_wdata;
            wait_d      = 4'(WAIT_CYCLES);
            state_d     = oor ? ERR : ACCESS;
            ram_read_d  = !oor && !bus.cpu_we;
            ram_write_d = !oor && bus.cpu_we;
        end else if (state_q == ACCESS) begin
            // the store strobe is never re-raised, so only the first cycle writes
            if (wait_q != 4'd0) begin
                wait_d     = wait_q - 4'd1;
                ram_read_d = !we_q;
            end else begin
                state_d = ACK;
                rdata_d = we_q ? rdata_q : bus.ram_dout;
            end
        end else if (state_q == ACK) begin
            state_d    = IDLE;
            rd_count_d = (!we_q && rd_count_q != 16'hFFFF) ? rd_count_q + 16'd1 : rd_count_q;
            wr_count_d = (we_q && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
        end else if (state_q == ERR) begin
            state_d = IDLE;
        end
        ack_d  = state_d == ACK || state_d == ERR;
        err_d  = state_d == ERR;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            wait_q      <= 4'd0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rdata_q     <= '0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            rd_count_q  <= 16'd0;
            wr_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rdata_q     <= rdata_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_err   = err_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.ram_read  = ram_read_q;
    assign bus.ram_write = ram_write_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign busy          = busy_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: two controllers (WAIT_CYCLES 0 and 2) on negedge RAM models,
// checked against a word-array reference and per-request timing rules.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req = '0, we = '0, ack, err, busy, rd, wr;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [31:0] din [2];
    logic [8:0]  raddr [2];
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];
    logic        pl_en = 1'b0;
    logic [8:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    logic [31:0] model_mem [2][512];
    logic [31:0] exp_rdata [2];
    int          exp_rd [2];
    int          exp_wr [2];
    int          vectors = 0;
    int          miscompares = 0;

    for (genvar g = 0; g < 2; g++) begin : gi
        mem_ctrl_if #(.ADDR_W(9), .DATA_W(32)) ifc ();
        logic [31:0] mem [512];
        logic [31:0] dout = '0;
        mem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2 * g)) u_dut (
            .clk(clk), .clr(clr), .bus(ifc.slave),
            .busy(busy[g]), .rd_count(rdc[g]), .wr_count(wrc[g])
        );
        always @(negedge clk) begin
            if (pl_en) mem[pl_a] <= pl_d;
            else if (ifc.ram_write) mem[ifc.ram_addr] <= ifc.ram_din;
            if (ifc.ram_read) dout <= mem[ifc.ram_addr];
        end
        assign ifc.cpu_req   = req[g];
        assign ifc.cpu_we    = we[g];
        assign ifc.cpu_addr  = addr[g];
        assign ifc.cpu_wdata = wdata[g];
        assign ifc.ram_dout  = dout;
        assign ack[g]        = ifc.cpu_ack;
        assign err[g]        = ifc.cpu_err;
        assign rdata[g]      = ifc.cpu_rdata;
        assign rd[g]         = ifc.ram_read;
        assign wr[g]         = ifc.ram_write;
        assign raddr[g]      = ifc.ram_addr;
        assign din[g]        = ifc.ram_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk({tag, "_ack"}, 32'(ack[s]), 0);
        chk({tag, "_busy"}, 32'(busy[s]), 0);
        chk({tag, "_strobes"}, 32'({rd[s], wr[s]}), 0);
        chk({tag, "_rdata"}, rdata[s], exp_rdata[s]);
        chk({tag, "_rdcnt"}, 32'(rdc[s]), 32'(exp_rd[s]));
        chk({tag, "_wrcnt"}, 32'(wrc[s]), 32'(exp_wr[s]));
    endtask

    // One request on controller s; inputs are scrambled once accepted.
    task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
        int  lat, nr, nw, wt;
        bit  bad, got, oor;
        oor = |a[31:9];
        wt  = 2 * s;
        lat = 0; nr = 0; nw = 0; bad = 0; got = 0;
        @(negedge clk);
        req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            nr += int'(rd[s]);
            nw += int'(wr[s]);
            if ((rd[s] || wr[s]) && raddr[s] !== a[8:0]) bad = 1;
            if (wr[s] && din[s] !== d) bad = 1;
            got = ack[s];
            if (got) begin
                chk("err_flag", 32'(err[s]), 32'(oor));
                if (!oor && !w) exp_rdata[s] = model_mem[s][a[8:0]];
                chk("rdata_at_ack", rdata[s], exp_rdata[s]);
            end
            we[s] = 1'($urandom); addr[s] = $urandom; wdata[s] = $urandom;
        end
        req[s] = 1'b0;
        chk("ack_latency", 32'(lat), oor ? 32'd1 : 32'(2 + wt));
        chk("read_cycles", 32'(nr), (!oor && !w) ? 32'(1 + wt) : 32'd0);
        chk("write_cycles", 32'(nw), (!oor && w) ? 32'd1 : 32'd0);
        chk("strobe_addr_data", 32'(bad), 0);
        if (!oor && w) begin
            model_mem[s][a[8:0]] = d;
            exp_wr[s]++;
        end
        if (!oor && !w) exp_rd[s]++;
        @(negedge clk);
        chk_idle(s, "post_txn");
    endtask

    initial begin
        int t, t1, t2, nack;
        logic [31:0] d, a;
        for (int s = 0; s < 2; s++) begin
            addr[s] = '0; wdata[s] = '0; exp_rdata[s] = '0; exp_rd[s] = 0; exp_wr[s] = 0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk_idle(s, "reset");
            chk("reset_ram_addr", 32'(raddr[s]), 0);
            chk("reset_err", 32'(err[s]), 0);
        end
        clr = 1'b0;
        for (int i = 0; i < 512; i++) begin
            @(posedge clk);
            d = (i == 'h75) ? 32'h0000F0F0 : (i == 'hBA) ? 32'h00000069 : $urandom;
            pl_en = 1'b1; pl_a = 9'(i); pl_d = d;
            model_mem[0][i] = d; model_mem[1][i] = d;
        end
        @(posedge clk);
        pl_en = 1'b0;

        txn(0, 0, 32'h75, 0);
        chk("load_75", rdata[0], 32'h0000F0F0);
        txn(0, 1, 32'h90, 32'h67);
        txn(0, 0, 32'h90, 0);
        chk("load_90", rdata[0], 32'h00000067);
        txn(0, 1, 32'h1FF, 32'hDEADBEEF);
        txn(0, 0, 32'h1FF, 0);
        chk("load_1ff", rdata[0], 32'hDEADBEEF);
        txn(0, 0, 32'h200, 0);
        chk("oor_rdata_kept", rdata[0], 32'hDEADBEEF);
        txn(1, 0, 32'h75, 0);
        chk("wait2_load_75", rdata[1], 32'h0000F0F0);
        txn(1, 1, 32'h80000001, 32'h1234);

        // back-to-back loads with req held high through the first ack
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h75;
        t = 0; t1 = 0; t2 = 0; nack = 0;
        while (t < 30 && nack < 2) begin
            @(negedge clk);
            t++;
            if (ack[0]) begin
                nack++;
                if (nack == 1) begin
                    t1 = t;
                    chk("b2b_first", rdata[0], 32'h0000F0F0);
                    addr[0] = 32'hBA;
                end else t2 = t;
            end
        end
        req[0] = 1'b0;
        chk("b2b_acks", 32'(nack), 2);
        chk("b2b_spacing", 32'(t2 - t1), 3);
        chk("b2b_second", rdata[0], 32'h00000069);
        exp_rd[0] += 2;
        exp_rdata[0] = 32'h00000069;
        @(negedge clk);
        chk_idle(0, "b2b_done");

        // reset while a store on the slow controller is in ACCESS
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'hCAFE0001;
        @(negedge clk);
        chk("midrst_write_seen", 32'(wr[1]), 1);
        model_mem[1][9'h10] = 32'hCAFE0001;
        req[1] = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int s = 0; s < 2; s++) begin
            exp_rdata[s] = '0; exp_rd[s] = 0; exp_wr[s] = 0;
            chk_idle(s, "midrst");
            chk("midrst_err", 32'(err[s]), 0);
            chk("midrst_ram_addr", 32'(raddr[s]), 0);
        end
        txn(1, 0, 32'h10, 0);
        chk("after_rst_load", rdata[1], 32'hCAFE0001);

        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h200) : 32'($urandom_range(0, 511));
            txn(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
